// File: rtl/psum_buffer_fifo_pkg.sv
// Shared partial-sum buffer constants used by the PE chain and its psum FIFOs.
package psum_buffer_fifo_pkg;

   localparam int PSUM_DATA_WIDTH     = 16;
   localparam int PSUM_BUF_DEPTH      = 16;
   localparam int PSUM_BUF_ADDR_WIDTH = 4;

endpackage

// File: rtl/psum_buffer_fifo_mem.sv
// Register array for the psum FIFO: one synchronous write port, one asynchronous
// read port, and a synchronous active-low reset that clears every entry.
module psum_fifo_mem
   import psum_buffer_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = PSUM_DATA_WIDTH,
   parameter int DEPTH      = PSUM_BUF_DEPTH,
   parameter int ADDR_WIDTH = PSUM_BUF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/psum_buffer_fifo.sv
// First-word-fall-through partial-sum FIFO between two PEs.
// Define PSUM_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module psum_buffer_fifo
   import psum_buffer_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = PSUM_DATA_WIDTH,
   parameter int DEPTH      = PSUM_BUF_DEPTH,
   parameter int ADDR_WIDTH = PSUM_BUF_ADDR_WIDTH,
   parameter int AF_LEVEL   = DEPTH - 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  wen,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  ready,
   output logic                  almost_full,
   input  logic                  ren,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  valid,
   output logic [ADDR_WIDTH:0]   count
`ifdef PSUM_FIFO_ERR_EN
   ,
   output logic                  overflow,
   output logic                  underflow
`endif
);

   localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   AF_CNT   = (ADDR_WIDTH + 1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] head;

   // Status comes only from the registered count, so no request loops back combinationally.
   assign ready       = (count_q != FULL_CNT);
   assign valid       = (count_q != '0);
   assign almost_full = (count_q >= AF_CNT);
   assign count       = count_q;
   assign dout        = valid ? head : '0;

   assign wr_acc = wen && ready && !clr;
   assign rd_acc = ren && valid && !clr;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (wr_acc) begin
            wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
         end
         if (rd_acc) begin
            rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   psum_fifo_mem #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_mem (
      .clk  (clk),
      .rst  (rst),
      .we   (wr_acc),
      .waddr(wptr_q),
      .wdata(din),
      .raddr(rptr_q),
      .rdata(head)
   );

`ifdef PSUM_FIFO_ERR_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // Flags record any dropped request and stay set until reset or a flush.
   always_comb begin
      overflow_d  = overflow_q | (wen & ~ready);
      underflow_d = underflow_q | (ren & ~valid);
      if (clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   // Dropped writes and empty pops simply leave the state unchanged.
`endif

endmodule

// File: tb/tb_psum_buffer_fifo.sv
// Directed self-checking bench for psum_buffer_fifo (default depth and a depth-5 wrap instance).
module tb_psum_buffer_fifo;

   logic        clk = 1'b0;
   logic        rst, clr, wen, ren;
   logic [15:0] din;
   logic        ready, almost_full, valid;
   logic [15:0] dout;
   logic [4:0]  count;
`ifdef PSUM_FIFO_ERR_EN
   logic        overflow, underflow;
   logic        overflow5, underflow5;
`endif

   logic        clr5, wen5, ren5;
   logic [15:0] din5;
   logic        ready5, almost_full5, valid5;
   logic [15:0] dout5;
   logic [3:0]  count5;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   psum_buffer_fifo dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .wen        (wen),
      .din        (din),
      .ready      (ready),
      .almost_full(almost_full),
      .ren        (ren),
      .dout       (dout),
      .valid      (valid),
      .count      (count)
`ifdef PSUM_FIFO_ERR_EN
      ,
      .overflow   (overflow),
      .underflow  (underflow)
`endif
   );

   psum_buffer_fifo #(
      .DATA_WIDTH(16),
      .DEPTH     (5),
      .ADDR_WIDTH(3)
   ) dut5 (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr5),
      .wen        (wen5),
      .din        (din5),
      .ready      (ready5),
      .almost_full(almost_full5),
      .ren        (ren5),
      .dout       (dout5),
      .valid      (valid5),
      .count      (count5)
`ifdef PSUM_FIFO_ERR_EN
      ,
      .overflow   (overflow5),
      .underflow  (underflow5)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clr  = 1'b0;
      wen  = 1'b0;
      ren  = 1'b0;
      din  = '0;
      clr5 = 1'b0;
      wen5 = 1'b0;
      ren5 = 1'b0;
      din5 = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      // Hold clr high during reset to confirm reset takes over regardless.
      idle();
      clr = 1'b1;
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      clr = 1'b0;
      tests_run += 5;
      if (ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
      if (valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
      if (count !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
      if (dout !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_dout: got %h expected 0000", dout); end
      if (almost_full !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_af: got %b expected 0", almost_full); end
`ifdef PSUM_FIFO_ERR_EN
      tests_run += 2;
      if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
      if (underflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_underflow: got %b expected 0", underflow); end
`endif
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 16; i++) begin
         wen = 1'b1;
         din = 16'(i);
         tick();
         if (i == 13) begin
            tests_run++;
            if (almost_full !== 1'b0) begin tests_failed++; $display("[TB] FAIL af_at_13: got %b expected 0", almost_full); end
         end
         if (i == 14) begin
            tests_run++;
            if (almost_full !== 1'b1) begin tests_failed++; $display("[TB] FAIL af_at_14: got %b expected 1", almost_full); end
         end
      end
      wen = 1'b0;
      tests_run += 4;
      if (count !== 5'd16) begin tests_failed++; $display("[TB] FAIL fill_count: got %0d expected 16", count); end
      if (ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_ready: got %b expected 0", ready); end
      if (almost_full !== 1'b1) begin tests_failed++; $display("[TB] FAIL fill_af: got %b expected 1", almost_full); end
      if (dout !== 16'h0001) begin tests_failed++; $display("[TB] FAIL fill_head: got %h expected 0001", dout); end
   endtask

   task automatic test_full_rw();
      // FIFO holds 1..16: the pop is taken, the write of 17 is dropped.
      wen = 1'b1;
      ren = 1'b1;
      din = 16'd17;
      tick();
      wen = 1'b0;
      ren = 1'b0;
      tests_run += 3;
      if (count !== 5'd15) begin tests_failed++; $display("[TB] FAIL full_rw_count: got %0d expected 15", count); end
      if (dout !== 16'h0002) begin tests_failed++; $display("[TB] FAIL full_rw_head: got %h expected 0002", dout); end
      if (ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_rw_ready: got %b expected 1", ready); end
`ifdef PSUM_FIFO_ERR_EN
      tests_run++;
      if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_rw_overflow: got %b expected 1", overflow); end
`endif
      for (int i = 2; i <= 16; i++) begin
         tests_run++;
         if (dout !== 16'(i)) begin tests_failed++; $display("[TB] FAIL full_drain_%0d: got %h expected %h", i, dout, 16'(i)); end
         ren = 1'b1;
         tick();
      end
      ren = 1'b0;
      tests_run++;
      if (valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_drain_valid: got %b expected 0", valid); end
   endtask

   task automatic test_fill_drain();
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         wen = 1'b1;
         din = 16'h0100 + 16'(i);
         tick();
      end
      wen = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tests_run++;
         if (dout !== 16'h0100 + 16'(i)) begin tests_failed++; $display("[TB] FAIL order_%0d: got %h expected %h", i, dout, 16'h0100 + 16'(i)); end
         ren = 1'b1;
         tick();
      end
      ren = 1'b0;
      tests_run += 3;
      if (valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL order_valid: got %b expected 0", valid); end
      if (count !== 5'd0) begin tests_failed++; $display("[TB] FAIL order_count: got %0d expected 0", count); end
      if (dout !== 16'h0000) begin tests_failed++; $display("[TB] FAIL order_dout: got %h expected 0000", dout); end
   endtask

   task automatic test_empty_rw();
      do_reset();
      wen = 1'b1;
      ren = 1'b1;
      din = 16'h00AA;
      tick();
      idle();
      tests_run += 3;
      if (valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL empty_rw_valid: got %b expected 1", valid); end
      if (dout !== 16'h00AA) begin tests_failed++; $display("[TB] FAIL empty_rw_dout: got %h expected 00aa", dout); end
      if (count !== 5'd1) begin tests_failed++; $display("[TB] FAIL empty_rw_count: got %0d expected 1", count); end
`ifdef PSUM_FIFO_ERR_EN
      tests_run += 2;
      if (underflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL empty_rw_underflow: got %b expected 1", underflow); end
      if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL empty_rw_overflow: got %b expected 0", overflow); end
`endif
   endtask

   task automatic test_clr();
      do_reset();
      ren = 1'b1;
      tick();
      ren = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         wen = 1'b1;
         din = 16'h0030 + 16'(i);
         tick();
      end
      tests_run++;
      if (count !== 5'd3) begin tests_failed++; $display("[TB] FAIL clr_pre_count: got %0d expected 3", count); end
      clr = 1'b1;
      wen = 1'b1;
      din = 16'h0055;
      tick();
      idle();
      tests_run += 3;
      if (count !== 5'd0) begin tests_failed++; $display("[TB] FAIL clr_count: got %0d expected 0", count); end
      if (valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL clr_valid: got %b expected 0", valid); end
      if (dout !== 16'h0000) begin tests_failed++; $display("[TB] FAIL clr_dout: got %h expected 0000", dout); end
`ifdef PSUM_FIFO_ERR_EN
      tests_run++;
      if (underflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL clr_underflow: got %b expected 0", underflow); end
`endif
      wen = 1'b1;
      din = 16'h0077;
      tick();
      wen = 1'b0;
      tests_run += 2;
      if (dout !== 16'h0077) begin tests_failed++; $display("[TB] FAIL clr_new_head: got %h expected 0077", dout); end
      if (count !== 5'd1) begin tests_failed++; $display("[TB] FAIL clr_new_count: got %0d expected 1", count); end
   endtask

   task automatic test_wrap();
      // Depth-5 instance: one word primed, then 12 write+pop pairs walk both pointers past 4.
      do_reset();
      wen5 = 1'b1;
      din5 = 16'h0020;
      tick();
      for (int i = 1; i <= 12; i++) begin
         tests_run++;
         if (dout5 !== 16'h0020 + 16'(i - 1)) begin tests_failed++; $display("[TB] FAIL wrap_%0d: got %h expected %h", i, dout5, 16'h0020 + 16'(i - 1)); end
         wen5 = 1'b1;
         ren5 = 1'b1;
         din5 = 16'h0020 + 16'(i);
         tick();
      end
      wen5 = 1'b0;
      ren5 = 1'b0;
      tests_run += 2;
      if (count5 !== 4'd1) begin tests_failed++; $display("[TB] FAIL wrap_count: got %0d expected 1", count5); end
      if (dout5 !== 16'h002C) begin tests_failed++; $display("[TB] FAIL wrap_last: got %h expected 002c", dout5); end
   endtask

   initial begin
      rst = 1'b0;
      idle();
      test_reset();
      test_fill();
      test_full_rw();
      test_fill_drain();
      test_empty_rw();
      test_clr();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
